// File: rtl/div_ctrl.sv
// div_ctrl: iterative 32-bit RISC-V divider (DIV/DIVU/REM/REMU), one restoring step per cycle.
// Ports: clk, reset_n, start, op, dividend, divisor, kill -> stall_o, div_wb, result, busy.
module div_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        kill,
    output logic        stall_o,
    output logic        div_wb,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quot;
    logic [31:0] dvsr;
    logic        qsign;
    logic        rsign;
    logic        is_rem;

    logic        accept;
    logic        signed_op;
    logic        div_zero;
    logic        ovf;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] shifted;
    logic [32:0] trial;

    assign accept    = (state == IDLE) & start & ~kill;
    assign signed_op = ~op[0];
    assign div_zero  = (divisor == 32'd0);
    assign ovf       = signed_op & (dividend == 32'h8000_0000)
                     & (divisor == 32'hFFFF_FFFF);

    assign abs_a = (signed_op & dividend[31]) ? (-dividend) : dividend;
    assign abs_b = (signed_op & divisor[31])  ? (-divisor)  : divisor;

    // rem < dvsr always holds, so the 33-bit difference never wraps and
    // bit 32 is a reliable borrow.
    assign shifted = {rem, quot[31]};
    assign trial   = shifted - {1'b0, dvsr};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (div_zero | ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                if (kill) begin
                    state_nxt = IDLE;
                end else if (cnt == 6'd31) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = kill ? IDLE : DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= 6'd0;
            rem    <= 32'd0;
            quot   <= 32'd0;
            dvsr   <= 32'd0;
            qsign  <= 1'b0;
            rsign  <= 1'b0;
            is_rem <= 1'b0;
            result <= 32'd0;
        end else begin
            if (accept) begin
                if (div_zero) begin
                    result <= op[1] ? dividend : 32'hFFFF_FFFF;
                end else if (ovf) begin
                    result <= op[1] ? 32'd0 : 32'h8000_0000;
                end else begin
                    rem    <= 32'd0;
                    quot   <= abs_a;
                    dvsr   <= abs_b;
                    qsign  <= signed_op & (dividend[31] ^ divisor[31]);
                    rsign  <= signed_op & dividend[31];
                    is_rem <= op[1];
                    cnt    <= 6'd0;
                end
            end
            if (state == CALC) begin
                cnt  <= cnt + 6'd1;
                rem  <= trial[32] ? shifted[31:0] : trial[31:0];
                quot <= {quot[30:0], ~trial[32]};
            end
            // A flushed FIX leaves the previous result untouched.
            if ((state == FIX) && !kill) begin
                if (is_rem) begin
                    result <= rsign ? (-rem) : rem;
                end else begin
                    result <= qsign ? (-quot) : quot;
                end
            end
        end
    end

    assign busy   = (state != IDLE);
    assign div_wb = (state == DONE) & ~kill;
    // Gated by reset_n so a start held during reset cannot raise a stall.
    assign stall_o = reset_n
                   & (accept | (state == CALC) | (state == FIX));

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed bench for div_ctrl with a latency/arithmetic reference model.
// Per-cycle compare of stall_o, busy, div_wb, result plus literal expectations.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        kill = 1'b0;
    logic        stall_o;
    logic        div_wb;
    logic [31:0] result;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    div_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .kill     (kill),
        .stall_o  (stall_o),
        .div_wb   (div_wb),
        .result   (result),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result of a RISC-V M-extension divide.
    function automatic logic [31:0] mdl(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        int sa;
        int sb;
        logic ov;
        sa = a;
        sb = b;
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            2'd0: mdl = (b == 0) ? 32'hFFFF_FFFF :
                        ov ? 32'h8000_0000 : 32'(sa / sb);
            2'd1: mdl = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2: mdl = (b == 0) ? a : ov ? 32'd0 : 32'(sa % sb);
            default: mdl = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int mdl_lat(input logic [1:0] o,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // left = cycles until the writeback cycle; 1 means "this is the DONE cycle".
    int          left = 0;
    logic [31:0] mres = 32'd0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left <= 0;
        end else if (left == 0) begin
            if (start && !kill) begin
                left <= mdl_lat(op, dividend, divisor);
                mres <= mdl(op, dividend, divisor);
            end
        end else if (left > 1 && kill) begin
            left <= 0;
        end else begin
            left <= left - 1;
        end
    end

    always @(negedge clk) begin
        logic ewb;
        logic est;
        ewb = reset_n && (left == 1) && !kill;
        est = reset_n && ((left > 1) || (left == 0 && start && !kill));
        check("cyc_busy", {31'd0, busy}, {31'd0, (left != 0)});
        check("cyc_stall", {31'd0, stall_o}, {31'd0, est});
        check("cyc_wb", {31'd0, div_wb}, {31'd0, ewb});
        if (ewb) begin
            check("cyc_result", result, mres);
        end
        if (!reset_n) begin
            check("cyc_rst_result", result, 32'd0);
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int lat, input logic hold, input string nm);
        int n;
        logic [31:0] r;
        op = o;
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (hold) begin
            op = 2'd1;
            dividend = 32'd9;
            divisor = 32'd3;
        end else begin
            start = 1'b0;
        end
        n = 0;
        r = 32'd0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            @(negedge clk);
            if (div_wb) begin
                n = i;
                r = result;
            end
            if (hold && i == 20) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        check({nm, "_lat"}, 32'(n), 32'(lat));
        check({nm, "_res"}, r, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        check("mdl_div", mdl(2'd0, 32'd100, 32'd7), 32'd14);
        check("mdl_rem_neg", mdl(2'd2, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("mdl_remu", mdl(2'd3, 32'hFFFF_FFFF, 32'h10), 32'hF);
        check("mdl_ovf", mdl(2'd0, 32'h8000_0000, 32'hFFFF_FFFF),
              32'h8000_0000);

        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // First accept on the first edge with reset released.
        reset_n = 1'b1;
        do_op(2'd0, 32'd100, 32'd7, 32'd14, 34, 1'b0, "div_100_7");
        do_op(2'd2, 32'd100, 32'd7, 32'd2, 34, 1'b0, "rem_100_7");
        do_op(2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0, "div_m7_2");
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0, "rem_m7_2");
        do_op(2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 1'b0, "divu_max_1");
        do_op(2'd3, 32'hFFFF_FFFF, 32'h10, 32'hF, 34, 1'b0, "remu_max_16");
        do_op(2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, "div_by0");
        do_op(2'd3, 32'd5, 32'd0, 32'd5, 1, 1'b0, "remu_by0");
        do_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0,
              "div_ovf");
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0, "rem_ovf");
        do_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 1'b0, "divu_big");
        do_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b0,
              "remu_big");
        do_op(2'd0, 32'd12, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 34, 1'b0, "div_12_m3");
        do_op(2'd0, 32'd100, 32'd7, 32'd14, 34, 1'b1, "div_held_start");

        // Flush in CALC, then an immediate new accept.
        op = 2'd0;
        dividend = 32'd1000;
        divisor = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_idle", {31'd0, busy}, 32'd0);
        do_op(2'd0, 32'd50, 32'd5, 32'd10, 34, 1'b0, "after_kill");

        // Flush in DONE suppresses the strobe.
        op = 2'd0;
        dividend = 32'd5;
        divisor = 32'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        kill = 1'b1;
        @(negedge clk);
        check("kill_done_wb", {31'd0, div_wb}, 32'd0);
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_done_idle", {31'd0, busy}, 32'd0);

        // start together with kill in IDLE is not an accept.
        start = 1'b1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        kill = 1'b0;
        check("kill_idle_noacc", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-operation, with start held high.
        op = 2'd0;
        dividend = 32'd100;
        divisor = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        start = 1'b1;
        reset_n = 1'b0;
        #1;
        check("arst_stall", {31'd0, stall_o}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_wb", {31'd0, div_wb}, 32'd0);
        check("arst_result", result, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        reset_n = 1'b1;
        do_op(2'd2, 32'd100, 32'd7, 32'd2, 34, 1'b0, "post_rst_rem");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
